bus_cmd_ctrl: RTL and testbench

//  Parametrised successor to the intel8288 bus command controller. Decodes the
//  8088 status lines s_n into memory, I/O and INTA command strobes plus
//  ALE/DEN/DT-R/MCE. Unlike intel8288 it sequences T1-T2-Tw-T3-T4 with

---
 rtl/bus_cmd_ctrl_if.sv | 40 ++++
 rtl/bus_cmd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bus_cmd_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cmd_ctrl_if.sv
// Bus command controller signal bundle: CPU status/control inputs and bus command outputs.
// Latency: none, wiring only.
// Backpressure: none; ready is carried as a plain level to the controller.
//
// Ports (slave = controller view):
//    s_n[2:0]  CPU status {S2,S1,S0}, active-low encoding
//    aen_n     address enable, cen command enable, iob I/O bus mode, ready bus ready
//    mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n  command strobes (active low)
//    dtr, den, mce, ale, busy  bus control outputs
interface bus_cmd_ctrl_if;
   logic [2:0] s_n;
   logic       aen_n;
   logic       cen;
   logic       iob;
   logic       ready;
   logic       mrdc_n;
   logic       mwtc_n;
   logic       amwc_n;
   logic       iorc_n;
   logic       iowc_n;
   logic       aiowc_n;
   logic       inta_n;
   logic       dtr;
   logic       den;
   logic       mce;
   logic       ale;
   logic       busy;

   modport slave (
      input  s_n, aen_n, cen, iob, ready,
      output mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n,
             dtr, den, mce, ale, busy
   );

   modport master (
      output s_n, aen_n, cen, iob, ready,
      input  mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n,
             dtr, den, mce, ale, busy
   );
endinterface

// File: rtl/bus_cmd_ctrl.sv
// 8088 bus command controller: decodes s_n into command strobes, sequencing T1-T2-[Tw]-T3-T4.
// Latency: all outputs registered, one clock after the inputs that cause them.
// Backpressure: ready (USE_READY=1) stretches Tw after the fixed wait count expires.
//
// Ports:
//    i_clk    system clock, rising edge
//    i_reset  synchronous, active-high
//    io_bus   bus_cmd_ctrl_if.slave: status/control inputs, command and bus control outputs
module bus_cmd_ctrl #(
   parameter int WAIT_STATES = 0,
   parameter bit USE_READY   = 1'b1,
   parameter bit ADV_WRITE   = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   bus_cmd_ctrl_if.slave io_bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T1,
      ST_T2,
      ST_TW,
      ST_T3,
      ST_T4
   } state_t;

   localparam logic [2:0] C_INTA    = 3'b000;
   localparam logic [2:0] C_IOR     = 3'b001;
   localparam logic [2:0] C_IOW     = 3'b010;
   localparam logic [2:0] C_HALT    = 3'b011;
   localparam logic [2:0] C_CODE    = 3'b100;
   localparam logic [2:0] C_MEMR    = 3'b101;
   localparam logic [2:0] C_MEMW    = 3'b110;
   localparam logic [2:0] C_PASSIVE = 3'b111;

   // The first Tw is the one being entered, so the counter holds the
   // number of fixed Tw cycles still to come after the current one.
   localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t     r_state;
   logic [2:0] r_code;
   logic       r_armed;
   logic [3:0] r_wleft;
   logic       r_mrdc_n, r_mwtc_n, r_amwc_n, r_iorc_n, r_iowc_n, r_aiowc_n, r_inta_n;
   logic       r_dtr, r_den, r_mce, r_ale, r_busy;

   state_t     w_nxt_state;
   logic [2:0] w_nxt_code;
   logic [3:0] w_nxt_wleft;
   logic       w_start;
   logic       w_is_rd, w_is_wr;
   logic       w_rd_ph, w_wr_ph, w_adv_ph;
   logic       w_mem_ok, w_io_ok;
   logic       w_mrdc_n, w_mwtc_n, w_amwc_n, w_iorc_n, w_iowc_n, w_aiowc_n, w_inta_n;
   logic       w_dtr, w_den, w_mce, w_ale, w_busy;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_wleft = r_wleft;
      // A cycle needs PASSIVE seen on the previous edge; HALT never starts one.
      w_start     = (r_state == ST_IDLE) && r_armed &&
                    (io_bus.s_n != C_PASSIVE) && (io_bus.s_n != C_HALT);
      w_nxt_code  = w_start ? io_bus.s_n : r_code;

      case (r_state)
         ST_IDLE: if (w_start) w_nxt_state = ST_T1;
         ST_T1:   w_nxt_state = ST_T2;
         ST_T2: begin
            if ((WAIT_STATES != 0) || (USE_READY && !io_bus.ready)) begin
               w_nxt_state = ST_TW;
               w_nxt_wleft = WS_LOAD;
            end else begin
               w_nxt_state = ST_T3;
            end
         end
         ST_TW: begin
            if (r_wleft != 4'd0) begin
               w_nxt_wleft = r_wleft - 4'd1;
            end else if (!(USE_READY && !io_bus.ready)) begin
               w_nxt_state = ST_T3;
            end
         end
         ST_T3:   w_nxt_state = ST_T4;
         default: w_nxt_state = ST_IDLE;
      endcase

      // Output decode looks at the state being entered so that the registered
      // outputs line up with that state.
      w_is_rd  = (w_nxt_code == C_INTA) || (w_nxt_code == C_IOR) ||
                 (w_nxt_code == C_CODE) || (w_nxt_code == C_MEMR);
      w_is_wr  = (w_nxt_code == C_IOW) || (w_nxt_code == C_MEMW);
      w_rd_ph  = (w_nxt_state == ST_T2) || (w_nxt_state == ST_TW) || (w_nxt_state == ST_T3);
      w_wr_ph  = (w_nxt_state == ST_T3);
      w_adv_ph = ADV_WRITE ? w_rd_ph : w_wr_ph;

      w_mem_ok = io_bus.cen && !io_bus.aen_n;
      w_io_ok  = io_bus.cen && (!io_bus.aen_n || io_bus.iob);

      w_mrdc_n  = !(w_rd_ph  && ((w_nxt_code == C_MEMR) || (w_nxt_code == C_CODE)) && w_mem_ok);
      w_mwtc_n  = !(w_wr_ph  && (w_nxt_code == C_MEMW) && w_mem_ok);
      w_amwc_n  = !(w_adv_ph && (w_nxt_code == C_MEMW) && w_mem_ok);
      w_iorc_n  = !(w_rd_ph  && (w_nxt_code == C_IOR)  && w_io_ok);
      w_iowc_n  = !(w_wr_ph  && (w_nxt_code == C_IOW)  && w_io_ok);
      w_aiowc_n = !(w_adv_ph && (w_nxt_code == C_IOW)  && w_io_ok);
      w_inta_n  = !(w_rd_ph  && (w_nxt_code == C_INTA) && w_io_ok);

      w_ale  = (w_nxt_state == ST_T1);
      w_busy = (w_nxt_state != ST_IDLE);
      w_dtr  = !(w_busy && (w_nxt_state != ST_T4) && w_is_rd);
      w_den  = io_bus.cen && (((w_nxt_state == ST_T1) && w_is_wr) || w_rd_ph);
      w_mce  = (w_nxt_state == ST_T1) && (w_nxt_code == C_INTA);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_code    <= C_PASSIVE;
         r_armed   <= 1'b1;
         r_wleft   <= 4'd0;
         r_mrdc_n  <= 1'b1;
         r_mwtc_n  <= 1'b1;
         r_amwc_n  <= 1'b1;
         r_iorc_n  <= 1'b1;
         r_iowc_n  <= 1'b1;
         r_aiowc_n <= 1'b1;
         r_inta_n  <= 1'b1;
         r_dtr     <= 1'b1;
         r_den     <= 1'b0;
         r_mce     <= 1'b0;
         r_ale     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_code    <= w_nxt_code;
         r_armed   <= (io_bus.s_n == C_PASSIVE);
         r_wleft   <= w_nxt_wleft;
         r_mrdc_n  <= w_mrdc_n;
         r_mwtc_n  <= w_mwtc_n;
         r_amwc_n  <= w_amwc_n;
         r_iorc_n  <= w_iorc_n;
         r_iowc_n  <= w_iowc_n;
         r_aiowc_n <= w_aiowc_n;
         r_inta_n  <= w_inta_n;
         r_dtr     <= w_dtr;
         r_den     <= w_den;
         r_mce     <= w_mce;
         r_ale     <= w_ale;
         r_busy    <= w_busy;
      end
   end

   assign io_bus.mrdc_n  = r_mrdc_n;
   assign io_bus.mwtc_n  = r_mwtc_n;
   assign io_bus.amwc_n  = r_amwc_n;
   assign io_bus.iorc_n  = r_iorc_n;
   assign io_bus.iowc_n  = r_iowc_n;
   assign io_bus.aiowc_n = r_aiowc_n;
   assign io_bus.inta_n  = r_inta_n;
   assign io_bus.dtr     = r_dtr;
   assign io_bus.den     = r_den;
   assign io_bus.mce     = r_mce;
   assign io_bus.ale     = r_ale;
   assign io_bus.busy    = r_busy;

endmodule

// File: tb/tb_bus_cmd_ctrl.sv
// Testbench for bus_cmd_ctrl: three parameter sets driven with the same inputs.
// Latency: each vector's expected outputs are checked one clock after it is applied.
// Backpressure: ready is driven from the vector table.
module tb_bus_cmd_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bus_cmd_ctrl_if bus0 ();
   bus_cmd_ctrl_if bus1 ();
   bus_cmd_ctrl_if bus2 ();

   bus_cmd_ctrl #(.WAIT_STATES(0), .USE_READY(1'b1), .ADV_WRITE(1'b1)) u_dut0 (
      .i_clk(clk), .i_reset(reset), .io_bus(bus0));
   bus_cmd_ctrl #(.WAIT_STATES(1), .USE_READY(1'b0), .ADV_WRITE(1'b0)) u_dut1 (
      .i_clk(clk), .i_reset(reset), .io_bus(bus1));
   bus_cmd_ctrl #(.WAIT_STATES(2), .USE_READY(1'b1), .ADV_WRITE(1'b1)) u_dut2 (
      .i_clk(clk), .i_reset(reset), .io_bus(bus2));

   // {ale,busy,dtr,den,mce, mrdc_n,mwtc_n,amwc_n,iorc_n,iowc_n,aiowc_n,inta_n}
   logic [11:0] act0, act1, act2;
   assign act0 = {bus0.ale, bus0.busy, bus0.dtr, bus0.den, bus0.mce, bus0.mrdc_n, bus0.mwtc_n,
                  bus0.amwc_n, bus0.iorc_n, bus0.iowc_n, bus0.aiowc_n, bus0.inta_n};
   assign act1 = {bus1.ale, bus1.busy, bus1.dtr, bus1.den, bus1.mce, bus1.mrdc_n, bus1.mwtc_n,
                  bus1.amwc_n, bus1.iorc_n, bus1.iowc_n, bus1.aiowc_n, bus1.inta_n};
   assign act2 = {bus2.ale, bus2.busy, bus2.dtr, bus2.den, bus2.mce, bus2.mrdc_n, bus2.mwtc_n,
                  bus2.amwc_n, bus2.iorc_n, bus2.iowc_n, bus2.aiowc_n, bus2.inta_n};

   // control groups {ale,busy,dtr,den,mce}
   localparam logic [4:0] C_IDLE  = 5'b00100;
   localparam logic [4:0] C_T4    = 5'b01100;
   localparam logic [4:0] C_T1R   = 5'b11000;
   localparam logic [4:0] C_T1W   = 5'b11110;
   localparam logic [4:0] C_T1I   = 5'b11001;
   localparam logic [4:0] C_RD    = 5'b01010;
   localparam logic [4:0] C_WR    = 5'b01110;
   localparam logic [4:0] C_NODEN = 5'b01000;
   // command groups {mrdc_n,mwtc_n,amwc_n,iorc_n,iowc_n,aiowc_n,inta_n}
   localparam logic [6:0] K_OFF   = 7'b1111111;
   localparam logic [6:0] K_MRDC  = 7'b0111111;
   localparam logic [6:0] K_IORC  = 7'b1110111;
   localparam logic [6:0] K_INTA  = 7'b1111110;
   localparam logic [6:0] K_AMWC  = 7'b1101111;
   localparam logic [6:0] K_MWALL = 7'b1001111;
   localparam logic [6:0] K_AIOWC = 7'b1111101;
   localparam logic [6:0] K_IOALL = 7'b1111001;

   typedef struct {
      logic       rst;
      logic [2:0] s_n;
      logic       aen_n;
      logic       cen;
      logic       iob;
      logic       ready;
      int         dut;
      logic [4:0] ctl;
      logic [6:0] cmd;
   } vec_t;

   typedef struct {
      int          idx;
      int          dut;
      logic [11:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic v(input logic rst, input logic [2:0] s, input logic aen, input logic c,
                    input logic iob, input logic rdy, input int d,
                    input logic [4:0] ctl, input logic [6:0] cmd);
      vec_t e;
      e.rst = rst; e.s_n = s; e.aen_n = aen; e.cen = c; e.iob = iob; e.ready = rdy;
      e.dut = d; e.ctl = ctl; e.cmd = cmd;
      vecs.push_back(e);
   endtask

   // normal inputs: no reset, aen_n=0, cen=1, iob=0, ready=1
   task automatic n(input int d, input logic [2:0] s, input logic [4:0] ctl, input logic [6:0] cmd);
      v(1'b0, s, 1'b0, 1'b1, 1'b0, 1'b1, d, ctl, cmd);
   endtask

   task automatic apply(input logic rst, input logic [2:0] s, input logic aen, input logic c,
                        input logic iob, input logic rdy);
      reset = rst;
      bus0.s_n = s; bus0.aen_n = aen; bus0.cen = c; bus0.iob = iob; bus0.ready = rdy;
      bus1.s_n = s; bus1.aen_n = aen; bus1.cen = c; bus1.iob = iob; bus1.ready = rdy;
      bus2.s_n = s; bus2.aen_n = aen; bus2.cen = c; bus2.iob = iob; bus2.ready = rdy;
   endtask

   function automatic logic [11:0] act_of(input int d);
      case (d)
         0:       return act0;
         1:       return act1;
         default: return act2;
      endcase
   endfunction

   task automatic check_one();
      sb_t e;
      logic [11:0] a;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard: no expected entry queued");
      end else begin
         e = sb_q.pop_front();
         a = act_of(e.dut);
         if (a !== e.exp) begin
            n_err++;
            $display("FAIL vec%0d dut%0d: got ctl=%b cmd=%b, want ctl=%b cmd=%b",
                     e.idx, e.dut, a[11:7], a[6:0], e.exp[11:7], e.exp[6:0]);
         end
      end
   endtask

   // Runs one cycle of the given code from an armed idle and counts busy clocks.
   task automatic count_busy(input int d, input logic [2:0] code, input int exp_len);
      int  cnt;
      bit  done;
      logic [11:0] a;
      @(negedge clk); apply(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk); apply(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk); apply(1'b0, code,   1'b0, 1'b1, 1'b0, 1'b1);
      cnt  = 0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk); #1;
         apply(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
         a = act_of(d);
         if (a[10]) cnt++;
         else done = 1'b1;
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL busy_len dut%0d: busy never dropped within 40 clocks, want %0d", d, exp_len);
      end else if (cnt != exp_len) begin
         n_err++;
         $display("FAIL busy_len dut%0d code=%b: got %0d clocks, want %0d", d, code, cnt, exp_len);
      end
   endtask

   initial begin
      apply(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);

      // dut0 (WS=0, READY, ADV): reset state, MEMR
      v(1, 3'b111, 0, 1, 0, 1, 0, C_IDLE, K_OFF);
      n(0, 3'b101, C_T1R, K_OFF);
      n(0, 3'b111, C_RD, K_MRDC);
      n(0, 3'b111, C_RD, K_MRDC);
      n(0, 3'b111, C_T4, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // HALT gives no cycle
      n(0, 3'b011, C_IDLE, K_OFF);
      n(0, 3'b011, C_IDLE, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // s_n held at MEMR after a cycle: no restart until 111
      n(0, 3'b101, C_T1R, K_OFF);
      n(0, 3'b101, C_RD, K_MRDC);
      n(0, 3'b101, C_RD, K_MRDC);
      n(0, 3'b101, C_T4, K_OFF);
      n(0, 3'b101, C_IDLE, K_OFF);
      n(0, 3'b101, C_IDLE, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      n(0, 3'b101, C_T1R, K_OFF);
      n(0, 3'b111, C_RD, K_MRDC);
      n(0, 3'b111, C_RD, K_MRDC);
      n(0, 3'b111, C_T4, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // reset held 2 clocks in the middle of a MEMR T2
      n(0, 3'b101, C_T1R, K_OFF);
      n(0, 3'b111, C_RD, K_MRDC);
      v(1, 3'b111, 0, 1, 0, 1, 0, C_IDLE, K_OFF);
      v(1, 3'b111, 0, 1, 0, 1, 0, C_IDLE, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // MEMW with ready low for 3 clocks: 3 Tw, mwtc_n only in T3
      n(0, 3'b110, C_T1W, K_OFF);
      n(0, 3'b111, C_WR, K_AMWC);
      v(0, 3'b111, 0, 1, 0, 0, 0, C_WR, K_AMWC);
      v(0, 3'b111, 0, 1, 0, 0, 0, C_WR, K_AMWC);
      v(0, 3'b111, 0, 1, 0, 0, 0, C_WR, K_AMWC);
      n(0, 3'b111, C_WR, K_MWALL);
      n(0, 3'b111, C_T4, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // INTA with cen=0: no command, no den, mce still in T1
      v(0, 3'b000, 0, 0, 0, 1, 0, C_T1I, K_OFF);
      v(0, 3'b111, 0, 0, 0, 1, 0, C_NODEN, K_OFF);
      v(0, 3'b111, 0, 0, 0, 1, 0, C_NODEN, K_OFF);
      v(0, 3'b111, 0, 0, 0, 1, 0, C_T4, K_OFF);
      v(0, 3'b111, 0, 0, 0, 1, 0, C_IDLE, K_OFF);
      // INTA with aen_n=1, iob=0 gated; released when aen_n drops
      v(0, 3'b000, 1, 1, 0, 1, 0, C_T1I, K_OFF);
      v(0, 3'b111, 1, 1, 0, 1, 0, C_RD, K_OFF);
      n(0, 3'b111, C_RD, K_INTA);
      n(0, 3'b111, C_T4, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // IOR with aen_n=1, iob=1 still issues iorc_n
      v(0, 3'b001, 1, 1, 1, 1, 0, C_T1R, K_OFF);
      v(0, 3'b111, 1, 1, 1, 1, 0, C_RD, K_IORC);
      v(0, 3'b111, 1, 1, 1, 1, 0, C_RD, K_IORC);
      v(0, 3'b111, 1, 1, 1, 1, 0, C_T4, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);
      // MEMR with aen_n=1, iob=1: memory command still blocked
      v(0, 3'b101, 1, 1, 1, 1, 0, C_T1R, K_OFF);
      v(0, 3'b111, 1, 1, 1, 1, 0, C_RD, K_OFF);
      n(0, 3'b111, C_RD, K_MRDC);
      n(0, 3'b111, C_T4, K_OFF);
      n(0, 3'b111, C_IDLE, K_OFF);

      // dut2 (WS=2, READY, ADV): IOW, ready low once after the fixed waits -> 3 Tw
      v(1, 3'b111, 0, 1, 0, 1, 2, C_IDLE, K_OFF);
      n(2, 3'b010, C_T1W, K_OFF);
      n(2, 3'b111, C_WR, K_AIOWC);
      n(2, 3'b111, C_WR, K_AIOWC);
      v(0, 3'b111, 0, 1, 0, 0, 2, C_WR, K_AIOWC);
      v(0, 3'b111, 0, 1, 0, 0, 2, C_WR, K_AIOWC);
      n(2, 3'b111, C_WR, K_IOALL);
      n(2, 3'b111, C_T4, K_OFF);
      n(2, 3'b111, C_IDLE, K_OFF);
      // MEMR with ready high: exactly 2 Tw
      n(2, 3'b101, C_T1R, K_OFF);
      n(2, 3'b111, C_RD, K_MRDC);
      n(2, 3'b111, C_RD, K_MRDC);
      n(2, 3'b111, C_RD, K_MRDC);
      n(2, 3'b111, C_RD, K_MRDC);
      n(2, 3'b111, C_T4, K_OFF);
      n(2, 3'b111, C_IDLE, K_OFF);

      // dut1 (WS=1, no READY, normal write timing): MEMW, ready ignored
      v(1, 3'b111, 0, 1, 0, 1, 1, C_IDLE, K_OFF);
      n(1, 3'b110, C_T1W, K_OFF);
      v(0, 3'b111, 0, 1, 0, 0, 1, C_WR, K_OFF);
      v(0, 3'b111, 0, 1, 0, 0, 1, C_WR, K_OFF);
      v(0, 3'b111, 0, 1, 0, 0, 1, C_WR, K_MWALL);
      n(1, 3'b111, C_T4, K_OFF);
      n(1, 3'b111, C_IDLE, K_OFF);

      for (int i = 0; i < vecs.size(); i++) begin
         sb_t e;
         @(negedge clk);
         apply(vecs[i].rst, vecs[i].s_n, vecs[i].aen_n, vecs[i].cen, vecs[i].iob, vecs[i].ready);
         e.idx = i;
         e.dut = vecs[i].dut;
         e.exp = {vecs[i].ctl, vecs[i].cmd};
         sb_q.push_back(e);
         @(posedge clk); #1;
         check_one();
      end

      // busy length of a full cycle per parameter set
      count_busy(0, 3'b101, 4);
      count_busy(1, 3'b001, 5);
      count_busy(2, 3'b101, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
